// File: rtl/sys_cntr_tx_arb.sv
// Transmit-side system controller: round-robin drain of NUM_CH byte FIFOs into one UART TX
// with per-channel bursts and an acknowledge timeout.
module sys_cntr_tx_arb #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned BURST_W     = 4,
  parameter int unsigned ACK_TIMEOUT = 64,
  localparam int unsigned CH_W       = $clog2(NUM_CH)
) (
  input  logic                         CLK,
  input  logic                         Reset,
  input  logic                         Busy,
  input  logic                         can_send,
  input  logic [NUM_CH-1:0]            Empty,
  input  logic [NUM_CH*DATA_WIDTH-1:0] RD_DATA,
  input  logic [NUM_CH-1:0]            CH_Mask,
  input  logic [BURST_W-1:0]           Burst_Len,
  output logic [NUM_CH-1:0]            FIFO_EN,
  output logic [DATA_WIDTH-1:0]        TX_DATA,
  output logic                         TX_Valid,
  output logic [CH_W-1:0]              Grant_ID,
  output logic                         Timeout_Err
);

  localparam int unsigned AW = $clog2(ACK_TIMEOUT);

  typedef enum logic [2:0] {IDLE, POP, LOAD, WAIT_ACK, SEND} state_t;

  state_t                state, state_nxt;
  logic [BURST_W-1:0]    burst_cnt, burst_cnt_nxt, burst_max;
  logic [CH_W-1:0]       last_grant, last_grant_nxt, grant_nxt;
  logic [CH_W-1:0]       rr_pick, idx;
  logic                  rr_found;
  logic [AW-1:0]         ack_cnt, ack_cnt_nxt;
  logic [NUM_CH-1:0]     req, fifo_en_nxt;
  logic [DATA_WIDTH-1:0] tx_data_nxt;
  logic                  tx_valid_nxt, timeout_nxt, ready;

  assign req       = ~Empty & CH_Mask;
  assign ready     = !Busy | can_send;
  assign burst_max = (Burst_Len == '0) ? BURST_W'(1) : Burst_Len;

  // First requesting channel after last_grant, wrapping around.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    idx      = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      idx = CH_W'((32'(last_grant) + i) % NUM_CH);
      if (!rr_found && req[idx]) begin
        rr_found = 1'b1;
        rr_pick  = idx;
      end
    end
  end

  // The pop strobe is registered on the decision edge so that it is high during POP.
  always_comb begin
    state_nxt      = state;
    burst_cnt_nxt  = burst_cnt;
    last_grant_nxt = last_grant;
    grant_nxt      = Grant_ID;
    ack_cnt_nxt    = ack_cnt;
    fifo_en_nxt    = '0;
    tx_data_nxt    = TX_DATA;
    tx_valid_nxt   = TX_Valid;
    timeout_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (rr_found && ready) begin
          grant_nxt   = rr_pick;
          fifo_en_nxt = NUM_CH'(1) << rr_pick;
          state_nxt   = POP;
        end
      end
      POP: state_nxt = LOAD;
      LOAD: begin
        tx_data_nxt  = RD_DATA[32'(Grant_ID) * DATA_WIDTH +: DATA_WIDTH];
        tx_valid_nxt = 1'b1;
        ack_cnt_nxt  = '0;
        state_nxt    = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (Busy) begin
          tx_valid_nxt  = 1'b0;
          burst_cnt_nxt = burst_cnt + 1'b1;
          state_nxt     = SEND;
        end else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
          tx_valid_nxt   = 1'b0;
          timeout_nxt    = 1'b1;
          burst_cnt_nxt  = '0;
          last_grant_nxt = Grant_ID;
          state_nxt      = IDLE;
        end else begin
          ack_cnt_nxt = ack_cnt + 1'b1;
        end
      end
      SEND: begin
        if (ready) begin
          if (burst_cnt < burst_max && req[Grant_ID]) begin
            fifo_en_nxt = NUM_CH'(1) << Grant_ID;
            state_nxt   = POP;
          end else begin
            burst_cnt_nxt  = '0;
            last_grant_nxt = Grant_ID;
            state_nxt      = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      burst_cnt   <= '0;
      last_grant  <= CH_W'(NUM_CH - 1);
      ack_cnt     <= '0;
      FIFO_EN     <= '0;
      TX_DATA     <= '0;
      TX_Valid    <= 1'b0;
      Grant_ID    <= '0;
      Timeout_Err <= 1'b0;
    end else begin
      state       <= state_nxt;
      burst_cnt   <= burst_cnt_nxt;
      last_grant  <= last_grant_nxt;
      ack_cnt     <= ack_cnt_nxt;
      FIFO_EN     <= fifo_en_nxt;
      TX_DATA     <= tx_data_nxt;
      TX_Valid    <= tx_valid_nxt;
      Grant_ID    <= grant_nxt;
      Timeout_Err <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_sys_cntr_tx_arb.sv
// Directed bench for sys_cntr_tx_arb: FIFO and UART transmitter models on the falling edge,
// scenario tasks with hand-computed expectations.
module tb_sys_cntr_tx_arb;

  logic       CLK = 1'b0;
  logic       Reset, Busy, can_send;
  logic [3:0] Empty, CH_Mask, Burst_Len, FIFO_EN;
  logic [31:0] RD_DATA;
  logic [7:0] TX_DATA;
  logic       TX_Valid, Timeout_Err;
  logic [1:0] Grant_ID;

  int tests = 0;
  int fails = 0;

  // Stimulus configuration, written only by the main sequence.
  int cfg_cnt[4];
  int load_gen   = 0;
  bit model_en   = 1'b1;
  int busy_delay = 1;
  int busy_len   = 3;
  bit cs_en      = 1'b0;

  // Model state and observations, written only by the model process.
  int cnt[4];
  int seq[4];
  int seen_gen   = 0;
  int wcnt       = 0;
  int bcnt       = 0;
  bit prev_pop   = 1'b0;
  int onehot_bad = 0;
  int consec_bad = 0;
  int toerr_cnt  = 0;
  int pop_q[$];
  logic [7:0] tx_q[$];

  sys_cntr_tx_arb #(.NUM_CH(4), .DATA_WIDTH(8), .BURST_W(4), .ACK_TIMEOUT(64)) dut (
    .CLK(CLK), .Reset(Reset), .Busy(Busy), .can_send(can_send), .Empty(Empty),
    .RD_DATA(RD_DATA), .CH_Mask(CH_Mask), .Burst_Len(Burst_Len), .FIFO_EN(FIFO_EN),
    .TX_DATA(TX_DATA), .TX_Valid(TX_Valid), .Grant_ID(Grant_ID), .Timeout_Err(Timeout_Err)
  );

  always #5 CLK = ~CLK;

  // FIFO words are {channel+1, sequence}; the transmitter raises Busy busy_delay falling
  // edges after seeing TX_Valid and holds it busy_len cycles, can_send in the last one.
  initial begin
    Busy = 1'b0; can_send = 1'b0; Empty = 4'hF; RD_DATA = '0;
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; seq[i] = 0; end
    forever begin
      @(negedge CLK);
      if (load_gen != seen_gen) begin
        seen_gen = load_gen;
        for (int i = 0; i < 4; i++) begin cnt[i] = cfg_cnt[i]; seq[i] = 0; end
      end
      if (FIFO_EN != 4'b0000) begin
        if (!$onehot(FIFO_EN)) onehot_bad++;
        if (prev_pop) consec_bad++;
        for (int i = 0; i < 4; i++)
          if (FIFO_EN[i]) begin
            pop_q.push_back(i);
            RD_DATA[i*8 +: 8] = 8'((i + 1) * 16 + seq[i]);
            seq[i]++;
            if (cnt[i] > 0) cnt[i]--;
          end
      end
      prev_pop = (FIFO_EN != 4'b0000);
      for (int i = 0; i < 4; i++) Empty[i] = (cnt[i] == 0);
      if (Timeout_Err) toerr_cnt++;
      if (!model_en || !Reset) begin
        Busy = 1'b0; can_send = 1'b0; wcnt = 0; bcnt = 0;
      end else if (Busy && TX_Valid) begin
        bcnt = busy_len; can_send = cs_en && busy_len == 1;
      end else if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) Busy = 1'b0;
        can_send = cs_en && bcnt == 1;
      end else if (TX_Valid) begin
        wcnt++;
        if (wcnt >= busy_delay) begin
          Busy = 1'b1; bcnt = busy_len; wcnt = 0; can_send = cs_en && busy_len == 1;
        end
      end
      if (TX_Valid && Busy) tx_q.push_back(TX_DATA);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic load(input int c0, input int c1, input int c2, input int c3);
    @(posedge CLK); #1;
    cfg_cnt[0] = c0; cfg_cnt[1] = c1; cfg_cnt[2] = c2; cfg_cnt[3] = c3;
    load_gen++;
  endtask

  task automatic apply_reset();
    @(posedge CLK); #1;
    Reset = 1'b0; model_en = 1'b1; cs_en = 1'b0; busy_delay = 1; busy_len = 3;
    Burst_Len = 4'd1; CH_Mask = 4'hF;
    for (int i = 0; i < 4; i++) cfg_cnt[i] = 0;
    load_gen++;
    repeat (3) @(posedge CLK);
    #1 Reset = 1'b1;
  endtask

  task automatic wait_pop(input int limit, output bit found);
    found = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge CLK);
      if (FIFO_EN !== 4'b0000) begin found = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) cfg_cnt[i] = 0;
    load_gen++;
    repeat (3) @(negedge CLK);
    tests++;
    if ({FIFO_EN, TX_DATA, TX_Valid, Grant_ID, Timeout_Err} !== 17'h0) begin
      fails++;
      $display("FAIL reset_values: got %h expected 0", {FIFO_EN, TX_DATA, TX_Valid, Grant_ID, Timeout_Err});
    end
    @(posedge CLK); #1 Reset = 1'b1;
    repeat (5) @(negedge CLK);
    tests++;
    if ({FIFO_EN, TX_Valid} !== 5'h0) begin
      fails++; $display("FAIL idle_no_request: got %h expected 0", {FIFO_EN, TX_Valid});
    end
  endtask

  task automatic test_single();
    bit found;
    int bp, bt;
    logic [7:0] got;
    apply_reset();
    busy_delay = 2; busy_len = 4;
    bp = pop_q.size(); bt = tx_q.size();
    load(1, 0, 0, 0);
    wait_pop(20, found);
    tests++;
    if (!found) begin fails++; $display("FAIL single_pop_seen: got none expected pop"); end
    tests++;
    if (FIFO_EN !== 4'b0001) begin fails++; $display("FAIL single_fifo_en: got %b expected 0001", FIFO_EN); end
    tests++;
    if (Grant_ID !== 2'd0) begin fails++; $display("FAIL single_grant: got %0d expected 0", Grant_ID); end
    @(negedge CLK);
    tests++;
    if (FIFO_EN !== 4'b0000) begin fails++; $display("FAIL single_pop_width: got %b expected 0000", FIFO_EN); end
    @(negedge CLK);
    tests++;
    if (TX_Valid !== 1'b1 || TX_DATA !== 8'h10) begin
      fails++; $display("FAIL single_tx_data: got v=%b d=%h expected v=1 d=10", TX_Valid, TX_DATA);
    end
    @(negedge CLK);
    tests++;
    if (TX_Valid !== 1'b1) begin fails++; $display("FAIL single_hold: got %b expected 1", TX_Valid); end
    @(negedge CLK);
    tests++;
    if (TX_Valid !== 1'b0) begin fails++; $display("FAIL single_valid_drop: got %b expected 0", TX_Valid); end
    repeat (12) @(negedge CLK);
    @(posedge CLK); #1;
    tests++;
    if (pop_q.size() - bp !== 1) begin fails++; $display("FAIL single_pop_count: got %0d expected 1", pop_q.size() - bp); end
    got = (tx_q.size() > bt) ? tx_q[bt] : 8'hxx;
    tests++;
    if (got !== 8'h10 || tx_q.size() - bt !== 1) begin
      fails++; $display("FAIL single_accepted: got %h (n=%0d) expected 10 (n=1)", got, tx_q.size() - bt);
    end
  endtask

  task automatic test_round_robin();
    int bp, bt, boh, bcs, got_p;
    int exp_p[8];
    logic [7:0] exp_t[8];
    logic [7:0] got_t;
    exp_p = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp_t = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h11, 8'h21, 8'h31, 8'h41};
    apply_reset();
    bp = pop_q.size(); bt = tx_q.size(); boh = onehot_bad; bcs = consec_bad;
    load(2, 2, 2, 2);
    repeat (120) @(negedge CLK);
    @(posedge CLK); #1;
    tests++;
    if (pop_q.size() - bp !== 8) begin fails++; $display("FAIL rr_pop_count: got %0d expected 8", pop_q.size() - bp); end
    for (int k = 0; k < 8; k++) begin
      got_p = (pop_q.size() > bp + k) ? pop_q[bp + k] : -1;
      got_t = (tx_q.size() > bt + k) ? tx_q[bt + k] : 8'hxx;
      tests++;
      if (got_p !== exp_p[k]) begin fails++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, got_p, exp_p[k]); end
      tests++;
      if (got_t !== exp_t[k]) begin fails++; $display("FAIL rr_data[%0d]: got %h expected %h", k, got_t, exp_t[k]); end
    end
    tests++;
    if (onehot_bad - boh !== 0 || consec_bad - bcs !== 0) begin
      fails++; $display("FAIL rr_strobe_shape: got onehot_bad=%0d consec=%0d expected 0 0", onehot_bad - boh, consec_bad - bcs);
    end
  endtask

  task automatic test_burst_mask();
    int bp, bt, got_p, ch1;
    int exp_p[6];
    logic [7:0] exp_t[6];
    logic [7:0] got_t;
    exp_p = '{0, 0, 0, 2, 2, 0};
    exp_t = '{8'h10, 8'h11, 8'h12, 8'h30, 8'h31, 8'h13};
    apply_reset();
    Burst_Len = 4'd3; CH_Mask = 4'b1101;
    bp = pop_q.size(); bt = tx_q.size();
    load(4, 2, 2, 0);
    repeat (150) @(negedge CLK);
    @(posedge CLK); #1;
    tests++;
    if (pop_q.size() - bp !== 6) begin fails++; $display("FAIL burst_pop_count: got %0d expected 6", pop_q.size() - bp); end
    ch1 = 0;
    for (int k = bp; k < pop_q.size(); k++) if (pop_q[k] == 1) ch1++;
    tests++;
    if (ch1 !== 0) begin fails++; $display("FAIL burst_masked_ch1: got %0d pops expected 0", ch1); end
    for (int k = 0; k < 6; k++) begin
      got_p = (pop_q.size() > bp + k) ? pop_q[bp + k] : -1;
      got_t = (tx_q.size() > bt + k) ? tx_q[bt + k] : 8'hxx;
      tests++;
      if (got_p !== exp_p[k]) begin fails++; $display("FAIL burst_order[%0d]: got %0d expected %0d", k, got_p, exp_p[k]); end
      tests++;
      if (got_t !== exp_t[k]) begin fails++; $display("FAIL burst_data[%0d]: got %h expected %h", k, got_t, exp_t[k]); end
    end
  endtask

  task automatic test_burst_zero();
    int bp, got_p;
    int exp_p[4];
    exp_p = '{0, 1, 0, 1};
    apply_reset();
    Burst_Len = 4'd0;
    bp = pop_q.size();
    load(2, 2, 0, 0);
    repeat (80) @(negedge CLK);
    @(posedge CLK); #1;
    tests++;
    if (pop_q.size() - bp !== 4) begin fails++; $display("FAIL bz_pop_count: got %0d expected 4", pop_q.size() - bp); end
    for (int k = 0; k < 4; k++) begin
      got_p = (pop_q.size() > bp + k) ? pop_q[bp + k] : -1;
      tests++;
      if (got_p !== exp_p[k]) begin fails++; $display("FAIL bz_order[%0d]: got %0d expected %0d", k, got_p, exp_p[k]); end
    end
  endtask

  task automatic test_timeout();
    bit found;
    int be, bt;
    apply_reset();
    model_en = 1'b0;
    be = toerr_cnt; bt = tx_q.size();
    load(1, 1, 0, 0);
    wait_pop(20, found);
    tests++;
    if (!found || FIFO_EN !== 4'b0001) begin fails++; $display("FAIL to_first_pop: got %b expected 0001", FIFO_EN); end
    repeat (2) @(negedge CLK);
    tests++;
    if (TX_Valid !== 1'b1) begin fails++; $display("FAIL to_valid_start: got %b expected 1", TX_Valid); end
    repeat (63) @(negedge CLK);
    tests++;
    if (TX_Valid !== 1'b1 || Timeout_Err !== 1'b0) begin
      fails++; $display("FAIL to_still_waiting: got v=%b e=%b expected v=1 e=0", TX_Valid, Timeout_Err);
    end
    @(negedge CLK);
    tests++;
    if (TX_Valid !== 1'b0 || Timeout_Err !== 1'b1) begin
      fails++; $display("FAIL to_expire: got v=%b e=%b expected v=0 e=1", TX_Valid, Timeout_Err);
    end
    @(negedge CLK);
    tests++;
    if (Timeout_Err !== 1'b0) begin fails++; $display("FAIL to_pulse_width: got %b expected 0", Timeout_Err); end
    tests++;
    if (FIFO_EN !== 4'b0010 || Grant_ID !== 2'd1) begin
      fails++; $display("FAIL to_next_grant: got en=%b id=%0d expected en=0010 id=1", FIFO_EN, Grant_ID);
    end
    repeat (80) @(negedge CLK);
    @(posedge CLK); #1;
    tests++;
    if (toerr_cnt - be !== 2 || tx_q.size() - bt !== 0) begin
      fails++; $display("FAIL to_totals: got errs=%0d acc=%0d expected errs=2 acc=0", toerr_cnt - be, tx_q.size() - bt);
    end
  endtask

  task automatic test_back_to_back();
    bit found;
    int gap, bt;
    logic [7:0] got;
    apply_reset();
    cs_en = 1'b1; busy_delay = 1; busy_len = 5; Burst_Len = 4'd3;
    bt = tx_q.size();
    load(3, 0, 0, 0);
    wait_pop(20, found);
    tests++;
    if (!found) begin fails++; $display("FAIL b2b_first_pop: got none expected pop"); end
    gap = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge CLK);
      gap++;
      if (FIFO_EN !== 4'b0000) break;
    end
    tests++;
    if (gap !== 7) begin fails++; $display("FAIL b2b_pop_gap: got %0d expected 7", gap); end
    repeat (40) @(negedge CLK);
    @(posedge CLK); #1;
    got = (tx_q.size() > bt + 2) ? tx_q[bt + 2] : 8'hxx;
    tests++;
    if (tx_q.size() - bt !== 3 || got !== 8'h12) begin
      fails++; $display("FAIL b2b_words: got n=%0d last=%h expected n=3 last=12", tx_q.size() - bt, got);
    end
  endtask

  task automatic test_reset_wait_ack();
    bit found;
    apply_reset();
    busy_delay = 20;
    load(0, 0, 1, 0);
    wait_pop(20, found);
    tests++;
    if (!found || FIFO_EN !== 4'b0100) begin fails++; $display("FAIL rst_pre_pop: got %b expected 0100", FIFO_EN); end
    repeat (3) @(negedge CLK);
    tests++;
    if (TX_Valid !== 1'b1 || TX_DATA !== 8'h30) begin
      fails++; $display("FAIL rst_pre_valid: got v=%b d=%h expected v=1 d=30", TX_Valid, TX_DATA);
    end
    @(posedge CLK); #1;
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) cfg_cnt[i] = 1;
    load_gen++;
    #1;
    tests++;
    if ({FIFO_EN, TX_DATA, TX_Valid, Grant_ID, Timeout_Err} !== 17'h0) begin
      fails++;
      $display("FAIL rst_async: got %h expected 0", {FIFO_EN, TX_DATA, TX_Valid, Grant_ID, Timeout_Err});
    end
    repeat (2) @(posedge CLK);
    #1 Reset = 1'b1;
    wait_pop(20, found);
    tests++;
    if (!found || FIFO_EN !== 4'b0001 || Grant_ID !== 2'd0) begin
      fails++; $display("FAIL rst_priority: got en=%b id=%0d expected en=0001 id=0", FIFO_EN, Grant_ID);
    end
  endtask

  initial begin
    Reset = 1'b0; CH_Mask = 4'hF; Burst_Len = 4'd1;
    for (int i = 0; i < 4; i++) cfg_cnt[i] = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_burst_mask();
    test_burst_zero();
    test_timeout();
    test_back_to_back();
    test_reset_wait_ack();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
